// File: rtl/load_store_unit.sv
// Load/store unit: CPU request/response front end to a word memory with byte/half lanes.
// Optional macro LSU_SUBWORD_EN enables sub-word loads and read-modify-write stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int unsigned DW         = 32;
  localparam logic [32:0] ADDR_LIMIT = 33'(64'(MEM_WORDS) << 2);
  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e          state_q;
  logic            store_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [1:0]      lane_q;
  logic [DW-1:0]   wdata_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [DW-1:0]   resp_rdata_q;
  logic [DW-1:0]   mem_addr_q;
  logic            mem_we_q;
  logic [DW-1:0]   mem_wd_q;

  logic            req_err_c;
  logic            direct_wr_c;

  // Lane extraction with zero/sign extension for loads
  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word,
                                                 input logic [1:0] size,
                                                 input logic sgn,
                                                 input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      SZ_BYTE: load_extract = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_HALF: load_extract = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace only the addressed lane of the captured word
  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                input logic [1:0] size,
                                                input logic [1:0] lane,
                                                input logic [DW-1:0] wdata);
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = (wdata & 32'h0000_00FF) << {lane, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = (wdata & 32'h0000_FFFF) << {lane[1], 4'b0000};
      end
      default: begin
        mask = '1;
        data = wdata;
      end
    endcase
    store_merge = (word & ~mask) | (data & mask);
  endfunction

  always_comb begin
    req_err_c = 1'b0;
    if (req_size == 2'b11) req_err_c = 1'b1;
    if (req_size == SZ_HALF && req_addr[0]) req_err_c = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err_c = 1'b1;
`ifndef LSU_SUBWORD_EN
    if (req_size != SZ_WORD) req_err_c = 1'b1;
`endif
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_err_c = 1'b1;
  end

  // Word stores skip the read; sub-word stores need the old word first
`ifdef LSU_SUBWORD_EN
  assign direct_wr_c = req_store && (req_size == SZ_WORD);
`else
  assign direct_wr_c = req_store;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (req_err_c) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= RESP;
            end else if (direct_wr_c) begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              mem_we_q   <= 1'b1;
              mem_wd_q   <= req_wdata;
              state_q    <= WR;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              state_q    <= RD;
            end
          end
        end
        RD: begin
          if (store_q) begin
            mem_wd_q <= store_merge(mem_rd, size_q, lane_q, wdata_q);
            mem_we_q <= 1'b1;
            state_q  <= WR;
          end else begin
            resp_rdata_q <= load_extract(mem_rd, size_q, signed_q, lane_q);
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            state_q      <= RESP;
          end
        end
        WR: begin
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 while reset is held
  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;

endmodule
